// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
// Pulls bytes out of a registered-read FIFO and presents them on a
// valid/ready output stream through a 2-entry skid buffer, so one byte per
// cycle can be sustained despite the 2-cycle read-to-valid latency.
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous, active-high reset
//   en          1 = fetch from the FIFO, 0 = stop fetching and drain
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid the cycle after an accepted read
//   fifo_re     FIFO read strobe (combinational)
//   m_valid     output stream valid (buffer not empty)
//   m_ready     output stream sink ready
//   m_data      output stream data (oldest buffered entry)
//   busy        1 while the controller is not IDLE
//   rd_count    bytes delivered since reset, modulo 2^16
// -----------------------------------------------------------------------------
module fifo_reader #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          fifo_empty,
   input  logic [DW-1:0] fifo_dout,
   output logic          fifo_re,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          busy,
   output logic [15:0]   rd_count
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned OCC_W = 2;
   localparam int unsigned SUM_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state_q,    state_d;
   logic [OCC_W-1:0]   occ_q,      occ_d;
   logic               inflight_q, inflight_d;
   logic [DW-1:0]      buf0_q,     buf0_d;
   logic [DW-1:0]      buf1_q,     buf1_d;
   logic [CNT_W-1:0]   rd_count_q, rd_count_d;

   logic               pop;
   logic [SUM_W-1:0]   committed;

   // Stream handshake and status derived directly from state
   assign m_valid  = (occ_q != '0);
   assign m_data   = buf0_q;
   assign busy     = (state_q != IDLE);
   assign rd_count = rd_count_q;
   assign pop      = (occ_q != '0) && m_ready;

   // Read strobe: only issue when the buffer will still have room for the
   // byte when it lands, counting the byte already in flight and any pop now.
   always_comb begin
      committed = SUM_W'(occ_q) + SUM_W'(inflight_q) - SUM_W'(pop);
      fifo_re   = (state_q == RUN) && !fifo_empty && (committed < SUM_W'(2));
   end

   // Controller next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (en) state_d = RUN;
         end
         RUN: begin
            if (!en) state_d = DRAIN;
         end
         DRAIN: begin
            if (en)
               state_d = RUN;
            else if ((occ_q == '0) && !inflight_q)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Buffer update: capture the in-flight byte and/or retire the head entry
   always_comb begin
      occ_d      = occ_q;
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;
      inflight_d = fifo_re;
      rd_count_d = rd_count_q;

      unique case ({inflight_q, pop})
         2'b11: begin
            // Simultaneous capture and pop: occupancy unchanged, order kept
            if (occ_q == OCC_W'(1)) begin
               buf0_d = fifo_dout;
            end else begin
               buf0_d = buf1_q;
               buf1_d = fifo_dout;
            end
         end
         2'b10: begin
            if (occ_q == '0)
               buf0_d = fifo_dout;
            else
               buf1_d = fifo_dout;
            occ_d = occ_q + OCC_W'(1);
         end
         2'b01: begin
            buf0_d = buf1_q;
            occ_d  = occ_q - OCC_W'(1);
         end
         default: begin
         end
      endcase

      if (pop) rd_count_d = rd_count_q + CNT_W'(1);
   end

   // State registers; reset discards buffered and in-flight data
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         occ_q      <= '0;
         inflight_q <= 1'b0;
         buf0_q     <= '0;
         buf1_q     <= '0;
         rd_count_q <= '0;
      end else begin
         state_q    <= state_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         rd_count_q <= rd_count_d;
      end
   end

endmodule

// File: tb/tb_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_reader
// Self-checking bench for fifo_reader. A behavioural FIFO (array + pointers)
// feeds the DUT; every byte accepted on the output stream is logged and
// compared against the sequence pushed into the FIFO.
// -----------------------------------------------------------------------------
module tb_fifo_reader;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 1 << 18;
   localparam int unsigned AW    = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          fifo_empty;
   logic [DW-1:0] fifo_dout;
   logic          fifo_re;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          busy;
   logic [15:0]   rd_count;

   int checks   = 0;
   int failures = 0;

   fifo_reader #(.DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_re    (fifo_re),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .busy       (busy),
      .rd_count   (rd_count)
   );

   always #5 clk = ~clk;

   // Behavioural FIFO with registered read data
   logic [DW-1:0] mem [DEPTH];
   int unsigned   wr_ptr = 0;
   int unsigned   rd_ptr = 0;

   assign fifo_empty = (rd_ptr == wr_ptr);

   initial fifo_dout = '0;

   always @(posedge clk) begin
      if (fifo_re && !fifo_empty) begin
         fifo_dout <= mem[AW'(rd_ptr)];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // Output monitor and protocol watchers
   logic [DW-1:0] obs_q [$];
   int            pops_since_rst = 0;
   int            re_empty_err   = 0;
   int            stab_err       = 0;
   logic          prev_stall     = 1'b0;
   logic [DW-1:0] prev_data      = '0;

   always @(posedge clk) begin
      if (fifo_re && fifo_empty) re_empty_err <= re_empty_err + 1;
      if (prev_stall && !(m_valid && (m_data == prev_data))) stab_err <= stab_err + 1;
      prev_stall <= m_valid && !m_ready && !rst;
      prev_data  <= m_data;
      if (rst)
         pops_since_rst <= 0;
      else if (m_valid && m_ready) begin
         obs_q.push_back(m_data);
         pops_since_rst <= pops_since_rst + 1;
      end
   end

   task automatic fifo_push(input logic [DW-1:0] d);
      mem[AW'(wr_ptr)] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   // Drops en and waits for IDLE; reports whether IDLE was reached in time
   task automatic drain_to_idle(output bit ok);
      en      = 1'b0;
      m_ready = 1'b1;
      ok      = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      wr_ptr = rd_ptr;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (m_valid !== 1'b0)   begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (fifo_re !== 1'b0)   begin failures++; $display("FAIL reset_fifo_re got=%b exp=0", fifo_re); end
      checks++; if (rd_count !== 16'd0) begin failures++; $display("FAIL reset_rd_count got=%h exp=0000", rd_count); end
      checks++; if (m_data !== 8'h00)   begin failures++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL idle_hold_busy got=%b exp=0", busy); end
   endtask

   // 16 preloaded bytes at full rate
   task automatic test_stream;
      bit ok;
      logic exp_re, exp_mv;
      obs_q.delete();
      for (int i = 1; i <= 16; i++) fifo_push(DW'(i));
      m_ready = 1'b1;
      en      = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         exp_re = (i <= 16);
         exp_mv = (i >= 3) && (i <= 18);
         checks++; if (fifo_re !== exp_re) begin failures++; $display("FAIL stream_fifo_re cyc=%0d got=%b exp=%b", i, fifo_re, exp_re); end
         checks++; if (m_valid !== exp_mv) begin failures++; $display("FAIL stream_m_valid cyc=%0d got=%b exp=%b", i, m_valid, exp_mv); end
         if (exp_mv) begin
            checks++; if (m_data !== DW'(i - 2)) begin failures++; $display("FAIL stream_m_data cyc=%0d got=%h exp=%h", i, m_data, DW'(i - 2)); end
         end
      end
      checks++; if (rd_count !== 16'd16) begin failures++; $display("FAIL stream_rd_count got=%0d exp=16", rd_count); end
      drain_to_idle(ok);
      checks++; if (!ok) begin failures++; $display("FAIL stream_idle busy=%b exp=0", busy); end
   endtask

   // Sink stalled: exactly two reads fill the buffer, head held, then released
   task automatic test_backpressure;
      bit ok;
      int re_cnt;
      int head_bad;
      logic [DW-1:0] exp [3];
      exp[0] = 8'hA5; exp[1] = 8'h5A; exp[2] = 8'h3C;
      obs_q.delete();
      for (int i = 0; i < 3; i++) fifo_push(exp[i]);
      m_ready  = 1'b0;
      en       = 1'b1;
      re_cnt   = 0;
      head_bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         re_cnt += int'(fifo_re);
         if (m_valid && (m_data !== 8'hA5)) head_bad++;
      end
      checks++; if (re_cnt != 2)       begin failures++; $display("FAIL bp_read_count got=%0d exp=2", re_cnt); end
      checks++; if (m_valid !== 1'b1)  begin failures++; $display("FAIL bp_m_valid got=%b exp=1", m_valid); end
      checks++; if (m_data !== 8'hA5)  begin failures++; $display("FAIL bp_m_data got=%h exp=a5", m_data); end
      checks++; if (head_bad != 0)     begin failures++; $display("FAIL bp_head_held bad_cycles=%0d exp=0", head_bad); end
      m_ready = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL bp_out_count got=%0d exp=3", obs_q.size()); end
      for (int i = 0; i < 3; i++) begin
         if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp[i]) begin failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, obs_q[i], exp[i]); end
         end
      end
      drain_to_idle(ok);
      checks++; if (!ok) begin failures++; $display("FAIL bp_idle busy=%b exp=0", busy); end
   endtask

   // Random sink stalls and bursty FIFO refill over 200 bytes
   task automatic test_random;
      bit ok;
      int pushed, mism, cyc, err0, stab0;
      logic [DW-1:0] exp_q [$];
      logic [DW-1:0] d;
      obs_q.delete();
      err0   = re_empty_err;
      stab0  = stab_err;
      pushed = 0;
      mism   = 0;
      en     = 1'b1;
      for (cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if ((pushed == 200) && (obs_q.size() >= 200)) break;
         m_ready = 1'($urandom_range(0, 1));
         if ((pushed < 200) && ($urandom_range(0, 9) < 4)) begin
            d = DW'($urandom);
            fifo_push(d);
            exp_q.push_back(d);
            pushed++;
         end
      end
      checks++; if (obs_q.size() != 200) begin failures++; $display("FAIL rand_out_count got=%0d exp=200", obs_q.size()); end
      for (int i = 0; i < 200; i++)
         if ((i < obs_q.size()) && (obs_q[i] !== exp_q[i])) mism++;
      checks++; if (mism != 0) begin failures++; $display("FAIL rand_sequence mismatched=%0d exp=0", mism); end
      checks++; if (re_empty_err != err0) begin failures++; $display("FAIL rand_re_when_empty got=%0d exp=0", re_empty_err - err0); end
      checks++; if (stab_err != stab0) begin failures++; $display("FAIL rand_stall_stability got=%0d exp=0", stab_err - stab0); end
      checks++; if (rd_count !== 16'(pops_since_rst)) begin failures++; $display("FAIL rand_rd_count got=%0d exp=%0d", rd_count, 16'(pops_since_rst)); end
      drain_to_idle(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rand_idle busy=%b exp=0", busy); end
   endtask

   // en dropped with one byte buffered and one in flight
   task automatic test_drain;
      int re_after, early_idle, left;
      bit idle_seen;
      logic [DW-1:0] d [4];
      obs_q.delete();
      for (int i = 0; i < 4; i++) begin
         d[i] = DW'($urandom);
         fifo_push(d[i]);
      end
      m_ready = 1'b1;
      en      = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (fifo_re !== 1'b1) begin failures++; $display("FAIL drain_pre_read got=%b exp=1", fifo_re); end
      en = 1'b0;
      re_after   = 0;
      early_idle = 0;
      idle_seen  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         re_after += int'(fifo_re);
         if (!busy && (obs_q.size() < 2)) early_idle++;
         if (!busy) begin
            idle_seen = 1'b1;
            break;
         end
      end
      left = int'(wr_ptr - rd_ptr);
      checks++; if (re_after != 0)     begin failures++; $display("FAIL drain_no_read got=%0d exp=0", re_after); end
      checks++; if (early_idle != 0)   begin failures++; $display("FAIL drain_busy_held early=%0d exp=0", early_idle); end
      checks++; if (!idle_seen)        begin failures++; $display("FAIL drain_idle busy=%b exp=0", busy); end
      checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL drain_count got=%0d exp=2", obs_q.size()); end
      if (obs_q.size() == 2) begin
         checks++; if (obs_q[0] !== d[0]) begin failures++; $display("FAIL drain_byte0 got=%h exp=%h", obs_q[0], d[0]); end
         checks++; if (obs_q[1] !== d[1]) begin failures++; $display("FAIL drain_byte1 got=%h exp=%h", obs_q[1], d[1]); end
      end
      checks++; if (left != 2)         begin failures++; $display("FAIL drain_fifo_left got=%0d exp=2", left); end
      wr_ptr = rd_ptr;
   endtask

   // 65537 deliveries after reset wrap the counter to 1
   task automatic test_wrap;
      bit ok;
      int mism;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      obs_q.delete();
      for (int i = 0; i < 65537; i++) fifo_push(DW'(i * 7 + 3));
      m_ready = 1'b1;
      en      = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         @(negedge clk);
         if (obs_q.size() >= 65537) break;
      end
      en = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (obs_q.size() != 65537) begin failures++; $display("FAIL wrap_out_count got=%0d exp=65537", obs_q.size()); end
      checks++; if (rd_count !== 16'h0001) begin failures++; $display("FAIL wrap_rd_count got=%h exp=0001", rd_count); end
      mism = 0;
      for (int i = 0; i < obs_q.size(); i++)
         if (obs_q[i] !== DW'(i * 7 + 3)) mism++;
      checks++; if (mism != 0) begin failures++; $display("FAIL wrap_sequence mismatched=%0d exp=0", mism); end
      drain_to_idle(ok);
      checks++; if (!ok) begin failures++; $display("FAIL wrap_idle busy=%b exp=0", busy); end
   endtask

   // Reset with a full buffer wins over en=1
   task automatic test_reset_midop;
      obs_q.delete();
      for (int i = 0; i < 5; i++) fifo_push(DW'($urandom));
      m_ready = 1'b0;
      en      = 1'b1;
      repeat (6) @(negedge clk);
      checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%b exp=1", m_valid); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (m_valid !== 1'b0)   begin failures++; $display("FAIL midrst_m_valid got=%b exp=0", m_valid); end
      checks++; if (rd_count !== 16'd0) begin failures++; $display("FAIL midrst_rd_count got=%h exp=0000", rd_count); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      checks++; if (fifo_re !== 1'b0)   begin failures++; $display("FAIL midrst_fifo_re got=%b exp=0", fifo_re); end
      rst = 1'b0;
      en  = 1'b0;
      wr_ptr = rd_ptr;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_after_busy got=%b exp=0", busy); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; m_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_random();
      test_drain();
      test_wrap();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
